issue_select: RTL and testbench

In-order dual-issue select stage directly downstream of the issue queue. Each cycle it inspects the two oldest queue entries and checks source-register readiness against an internal scoreboard, structural pipe limits and intra-pair hazards. It returns the pop count to the queue combinationally and registers the issued instructions into two execution-pipe input registers.

---
 rtl/issue_select_pkg.sv | 43 ++++
 rtl/issue_select_scoreboard.sv | 86 ++++++++
 rtl/issue_select.sv | 115 +++++++++++
 tb/tb_issue_select.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/issue_select_pkg.sv
// ---------------------------------------------------------------------------
// issue_select_pkg
//   Shared types and helpers for the dual-issue select stage.
//   - reg_addr_t  : architectural register index (full 5-bit width)
//   - iq_elem_t   : issue queue element as seen by the select stage
//   - writes_reg  : true when an element allocates a scoreboard entry
//   - pair_hazard : RAW/WAW check between an older and a younger element
// ---------------------------------------------------------------------------
package issue_select_pkg;

  localparam int ISQ_NUM_REGS = 32;
  localparam int REG_ADDR_W   = 5;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  typedef struct packed {
    reg_addr_t rs;
    reg_addr_t rt;
    reg_addr_t rd;
    logic      use_rs;
    logic      use_rt;
    logic      reg_write;
    logic      is_lsu;
  } iq_elem_t;

  // r0 is hardwired, so writes to it never make anything busy.
  function automatic logic writes_reg(input iq_elem_t e);
    return e.reg_write && (e.rd != '0);
  endfunction

  // The younger element must not read or overwrite the older one's result
  // within the same issue group.
  function automatic logic pair_hazard(input iq_elem_t older, input iq_elem_t younger);
    logic raw;
    logic waw;
    raw = writes_reg(older) &&
          ((younger.use_rs && (younger.rs == older.rd)) ||
           (younger.use_rt && (younger.rt == older.rd)));
    waw = writes_reg(older) && younger.reg_write && (younger.rd == older.rd);
    return raw || waw;
  endfunction

endpackage

// File: rtl/issue_select_scoreboard.sv
// ---------------------------------------------------------------------------
// issue_scoreboard
//   Busy-bit scoreboard for architectural registers.
//   Ports:
//     clk, rst          clock, synchronous active-high reset
//     flush             clears every busy bit on the next edge
//     set_en/set_addr   two allocation ports (issued destinations)
//     clr_en/clr_addr   two writeback ports
//     src_use/src_addr  four source lookups
//     src_ready         per-source readiness, including writeback bypass
//     busy              current busy vector
// ---------------------------------------------------------------------------
module issue_scoreboard
  import issue_select_pkg::*;
#(
  parameter int NUM_REGS = ISQ_NUM_REGS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic [1:0]          set_en,
  input  reg_addr_t [1:0]     set_addr,
  input  logic [1:0]          clr_en,
  input  reg_addr_t [1:0]     clr_addr,
  input  logic [3:0]          src_use,
  input  reg_addr_t [3:0]     src_addr,
  output logic [3:0]          src_ready,
  output logic [NUM_REGS-1:0] busy
);

  logic [NUM_REGS-1:0] busy_next;

  function automatic logic port_hit(input logic [1:0] en, input reg_addr_t [1:0] addr,
                                    input int r);
    logic h;
    h = 1'b0;
    for (int j = 0; j < 2; j++) begin
      if (en[j] && (int'(addr[j]) == r)) h = 1'b1;
    end
    return h;
  endfunction

  // Addresses outside the tracked range read as not busy instead of wrapping.
  function automatic logic busy_at(input logic [NUM_REGS-1:0] vec, input reg_addr_t a);
    logic b;
    b = 1'b0;
    for (int r = 0; r < NUM_REGS; r++) begin
      if (int'(a) == r) b = vec[r];
    end
    return b;
  endfunction

  function automatic logic clr_hit(input logic [1:0] en, input reg_addr_t [1:0] addr,
                                   input reg_addr_t a);
    return (en[0] && (addr[0] == a)) || (en[1] && (addr[1] == a));
  endfunction

  // A writeback in the current cycle makes its register ready immediately.
  always_comb begin
    src_ready = '0;
    for (int i = 0; i < 4; i++) begin
      src_ready[i] = !src_use[i] || (src_addr[i] == '0) ||
                     !busy_at(busy, src_addr[i]) ||
                     clr_hit(clr_en, clr_addr, src_addr[i]);
    end
  end

  // Set is applied after clear so an allocation wins over a same-cycle writeback.
  always_comb begin
    busy_next = busy;
    for (int r = 0; r < NUM_REGS; r++) begin
      if (port_hit(clr_en, clr_addr, r)) busy_next[r] = 1'b0;
      if (port_hit(set_en, set_addr, r)) busy_next[r] = 1'b1;
    end
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      busy <= '0;
    end else begin
      busy <= busy_next;
    end
  end

endmodule

// File: rtl/issue_select.sv
// ---------------------------------------------------------------------------
// issue_select
//   In-order dual-issue select stage behind the issue queue. Inspects the two
//   oldest queue entries, decides how many issue this cycle (returned to the
//   queue combinationally) and loads them into two execution-pipe registers.
//   Ports:
//     clk, rst       clock, synchronous active-high reset
//     iq_data        queue head entries, [0] oldest
//     iq_size        number of valid entries in iq_data (0..2)
//     issue_number   entries popped this cycle (0..2)
//     ex_ready       pipe i consumes ex_inst[i] this cycle
//     ex_valid       pipe register i holds an instruction
//     ex_inst        pipe registers; pipe 0 = ALU+LSU, pipe 1 = ALU only
//     wb_valid       writeback port active
//     wb_dest        writeback destination register
//     flush          pipeline redirect, drops all in-flight state
// ---------------------------------------------------------------------------
module issue_select
  import issue_select_pkg::*;
#(
  parameter int NUM_REGS = ISQ_NUM_REGS
) (
  input  logic            clk,
  input  logic            rst,
  input  iq_elem_t [1:0]  iq_data,
  input  logic [1:0]      iq_size,
  output logic [1:0]      issue_number,
  input  logic [1:0]      ex_ready,
  output logic [1:0]      ex_valid,
  output iq_elem_t [1:0]  ex_inst,
  input  logic [1:0]      wb_valid,
  input  reg_addr_t [1:0] wb_dest,
  input  logic            flush
);

  iq_elem_t            slot0;
  iq_elem_t            slot1;
  logic [1:0]          pipe_free;
  logic [3:0]          src_use;
  reg_addr_t [3:0]     src_addr;
  logic [3:0]          src_ready;
  logic [1:0]          set_en;
  reg_addr_t [1:0]     set_addr;
  logic                slot0_go;
  logic                slot1_go;
  logic [NUM_REGS-1:0] busy;

  assign slot0 = iq_data[0];
  assign slot1 = iq_data[1];

  // A pipe register can accept a new instruction when empty or draining.
  assign pipe_free = ~ex_valid | ex_ready;

  assign src_use  = {slot1.use_rt, slot1.use_rs, slot0.use_rt, slot0.use_rs};
  assign src_addr = {slot1.rt, slot1.rs, slot0.rt, slot0.rs};

  issue_scoreboard #(
    .NUM_REGS (NUM_REGS)
  ) u_sb (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .set_en    (set_en),
    .set_addr  (set_addr),
    .clr_en    (wb_valid),
    .clr_addr  (wb_dest),
    .src_use   (src_use),
    .src_addr  (src_addr),
    .src_ready (src_ready),
    .busy      (busy)
  );

  // Select: slot1 only follows slot0, never issues alone, and never to the
  // LSU-less pipe when it is a memory op.
  always_comb begin
    slot0_go = !rst && !flush && (iq_size >= 2'd1) &&
               src_ready[0] && src_ready[1] && pipe_free[0];
    slot1_go = slot0_go && (iq_size == 2'd2) &&
               src_ready[2] && src_ready[3] && !slot1.is_lsu &&
               pipe_free[1] && !pair_hazard(slot0, slot1);
  end

  assign issue_number = {1'b0, slot0_go} + {1'b0, slot1_go};

  always_comb begin
    set_en[0]   = slot0_go && writes_reg(slot0);
    set_en[1]   = slot1_go && writes_reg(slot1);
    set_addr[0] = slot0.rd;
    set_addr[1] = slot1.rd;
  end

  // ---- stage boundary: select -> execution-pipe input registers ----
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid <= '0;
      ex_inst  <= '0;
    end else if (flush) begin
      ex_valid <= '0;
    end else begin
      if (slot0_go) begin
        ex_valid[0] <= 1'b1;
        ex_inst[0]  <= slot0;
      end else if (pipe_free[0]) begin
        ex_valid[0] <= 1'b0;
      end
      if (slot1_go) begin
        ex_valid[1] <= 1'b1;
        ex_inst[1]  <= slot1;
      end else if (pipe_free[1]) begin
        ex_valid[1] <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_issue_select.sv
// ---------------------------------------------------------------------------
// tb_issue_select
//   Directed scenarios followed by randomized traffic from a modelled issue
//   queue; every cycle is compared against a behavioural reference model.
// ---------------------------------------------------------------------------
module tb_issue_select;
  import issue_select_pkg::*;

  logic            clk = 1'b0;
  logic            rst;
  iq_elem_t [1:0]  iq_data;
  logic [1:0]      iq_size;
  logic [1:0]      issue_number;
  logic [1:0]      ex_ready;
  logic [1:0]      ex_valid;
  iq_elem_t [1:0]  ex_inst;
  logic [1:0]      wb_valid;
  reg_addr_t [1:0] wb_dest;
  logic            flush;

  issue_select dut (
    .clk          (clk),
    .rst          (rst),
    .iq_data      (iq_data),
    .iq_size      (iq_size),
    .issue_number (issue_number),
    .ex_ready     (ex_ready),
    .ex_valid     (ex_valid),
    .ex_inst      (ex_inst),
    .wb_valid     (wb_valid),
    .wb_dest      (wb_dest),
    .flush        (flush)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state
  bit [31:0]      m_busy  = '0;
  bit [1:0]       m_valid = '0;
  iq_elem_t [1:0] m_inst  = '0;
  bit             e_g0, e_g1;
  bit [1:0]       e_free;
  int             e_n;
  int             got_n;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic iq_elem_t mk(input int rs, input int rt, input int rd,
                                  input bit us, input bit ut, input bit wr, input bit lsu);
    iq_elem_t e;
    e.rs = reg_addr_t'(rs);
    e.rt = reg_addr_t'(rt);
    e.rd = reg_addr_t'(rd);
    e.use_rs = us;
    e.use_rt = ut;
    e.reg_write = wr;
    e.is_lsu = lsu;
    return e;
  endfunction

  function automatic iq_elem_t rnd_elem();
    return mk($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
              1'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0),
              ($urandom_range(0, 3) == 0));
  endfunction

  // Source readiness straight from the rules: unused, r0, idle, or written back now.
  function automatic bit src_ok(input bit use_it, input reg_addr_t r);
    if (!use_it || r == 0) return 1'b1;
    if (!m_busy[r]) return 1'b1;
    for (int j = 0; j < 2; j++)
      if (wb_valid[j] && wb_dest[j] == r) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit depends(input iq_elem_t a, input iq_elem_t b);
    if (!a.reg_write || a.rd == 0) return 1'b0;
    return (b.use_rs && b.rs == a.rd) || (b.use_rt && b.rt == a.rd) ||
           (b.reg_write && b.rd == a.rd);
  endfunction

  task automatic model_eval();
    iq_elem_t d0, d1;
    d0 = iq_data[0];
    d1 = iq_data[1];
    e_free[0] = !m_valid[0] || ex_ready[0];
    e_free[1] = !m_valid[1] || ex_ready[1];
    e_g0 = !rst && !flush && iq_size >= 1 && src_ok(d0.use_rs, d0.rs) &&
           src_ok(d0.use_rt, d0.rt) && e_free[0];
    e_g1 = e_g0 && iq_size == 2 && src_ok(d1.use_rs, d1.rs) && src_ok(d1.use_rt, d1.rt) &&
           !d1.is_lsu && e_free[1] && !depends(d0, d1);
    e_n = int'(e_g0) + int'(e_g1);
  endtask

  task automatic model_update();
    bit g[2];
    g[0] = e_g0;
    g[1] = e_g1;
    if (rst) begin
      m_busy = '0; m_valid = '0; m_inst = '0;
    end else if (flush) begin
      m_busy = '0; m_valid = '0;
    end else begin
      for (int j = 0; j < 2; j++) if (wb_valid[j]) m_busy[wb_dest[j]] = 1'b0;
      for (int i = 0; i < 2; i++) begin
        if (g[i] && iq_data[i].reg_write && iq_data[i].rd != 0) m_busy[iq_data[i].rd] = 1'b1;
        if (g[i]) begin
          m_valid[i] = 1'b1;
          m_inst[i]  = iq_data[i];
        end else if (e_free[i]) begin
          m_valid[i] = 1'b0;
        end
      end
    end
  endtask

  // Inputs are set at the negedge before the call.
  task automatic cycle();
    #1;
    model_eval();
    got_n = int'(issue_number);
    chk("issue_number", 64'(issue_number), 64'(e_n));
    @(posedge clk);
    model_update();
    #1;
    chk("ex_valid", 64'(ex_valid), 64'(m_valid));
    chk("ex_inst", 64'(ex_inst), 64'(m_inst));
    chk("busy", 64'(dut.u_sb.busy), 64'(m_busy));
    @(negedge clk);
  endtask

  task automatic idle();
    rst = 1'b0; flush = 1'b0; wb_valid = '0; wb_dest = '0;
    ex_ready = 2'b11; iq_size = 2'd0;
  endtask

  iq_elem_t q[$];
  iq_elem_t saved;

  initial begin
    idle();
    rst = 1'b1;
    iq_data[0] = mk(1, 2, 3, 1, 1, 1, 0);
    iq_data[1] = mk(4, 5, 6, 1, 1, 1, 0);
    iq_size = 2'd2;
    cycle();
    chk("rst_n", 64'(got_n), 64'd0);
    cycle();
    chk("rst_valid", 64'(ex_valid), 64'd0);
    chk("rst_inst", 64'(ex_inst), 64'd0);
    chk("rst_busy", 64'(dut.u_sb.busy), 64'd0);

    // Entries beyond iq_size are ignored
    idle();
    cycle();
    chk("size0_n", 64'(got_n), 64'd0);

    // Independent pair
    idle();
    iq_data[0] = mk(1, 2, 3, 1, 1, 1, 0);
    iq_data[1] = mk(4, 5, 6, 1, 1, 1, 0);
    iq_size = 2'd2;
    cycle();
    chk("pair_n", 64'(got_n), 64'd2);
    chk("pair_valid", 64'(ex_valid), 64'd3);
    chk("pair_busy3", 64'(dut.u_sb.busy[3]), 64'd1);
    chk("pair_busy6", 64'(dut.u_sb.busy[6]), 64'd1);

    // RAW inside the pair, then wakeup on the writeback cycle
    idle();
    iq_data[0] = mk(1, 2, 3, 1, 1, 1, 0);
    iq_data[1] = mk(3, 0, 7, 1, 0, 1, 0);
    iq_size = 2'd2;
    cycle();
    chk("raw_n", 64'(got_n), 64'd1);
    iq_data[0] = mk(3, 0, 7, 1, 0, 1, 0);
    iq_data[1] = rnd_elem();
    iq_size = 2'd1;
    cycle();
    chk("raw_wait_n", 64'(got_n), 64'd0);
    wb_valid = 2'b01; wb_dest[0] = 5'd3;
    cycle();
    chk("raw_wake_n", 64'(got_n), 64'd1);
    chk("raw_wake_valid0", 64'(ex_valid[0]), 64'd1);

    // LSU cannot go to pipe 1; it issues next cycle from slot 0
    idle();
    iq_data[0] = mk(1, 2, 8, 1, 1, 1, 0);
    iq_data[1] = mk(4, 5, 10, 1, 1, 1, 1);
    iq_size = 2'd2;
    cycle();
    chk("lsu_n", 64'(got_n), 64'd1);
    iq_data[0] = mk(4, 5, 10, 1, 1, 1, 1);
    iq_size = 2'd1;
    cycle();
    chk("lsu_slot0_n", 64'(got_n), 64'd1);
    chk("lsu_pipe0", 64'(ex_inst[0]), 64'(mk(4, 5, 10, 1, 1, 1, 1)));

    // Backpressure on pipe 0
    idle();
    iq_data[0] = mk(1, 2, 11, 1, 1, 0, 0);
    iq_size = 2'd1;
    cycle();
    saved = ex_inst[0];
    ex_ready = 2'b00;
    iq_data[0] = mk(1, 2, 12, 1, 1, 0, 0);
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("bp_n", 64'(got_n), 64'd0);
      chk("bp_hold", 64'(ex_inst[0]), 64'(saved));
    end
    ex_ready = 2'b01;
    cycle();
    chk("bp_resume_n", 64'(got_n), 64'd1);

    // Flush with live state
    idle();
    iq_data[0] = mk(1, 2, 7, 1, 1, 1, 0);
    iq_data[1] = mk(4, 5, 13, 1, 1, 1, 0);
    iq_size = 2'd2;
    cycle();
    chk("pre_flush_valid", 64'(ex_valid), 64'd3);
    chk("pre_flush_busy7", 64'(dut.u_sb.busy[7]), 64'd1);
    flush = 1'b1;
    ex_ready = 2'b00;
    cycle();
    chk("flush_n", 64'(got_n), 64'd0);
    chk("flush_valid", 64'(ex_valid), 64'd0);
    chk("flush_busy", 64'(dut.u_sb.busy), 64'd0);

    // Set beats clear on the same register
    idle();
    iq_data[0] = mk(1, 2, 9, 1, 1, 1, 0);
    iq_size = 2'd1;
    wb_valid = 2'b01; wb_dest[0] = 5'd9;
    cycle();
    chk("collide_busy9", 64'(dut.u_sb.busy[9]), 64'd1);

    // Reset mid-stream
    idle();
    iq_data[0] = mk(1, 2, 14, 1, 1, 1, 0);
    iq_data[1] = mk(4, 5, 15, 1, 1, 1, 0);
    iq_size = 2'd2;
    cycle();
    rst = 1'b1;
    cycle();
    chk("midrst_n", 64'(got_n), 64'd0);
    chk("midrst_valid", 64'(ex_valid), 64'd0);
    chk("midrst_inst", 64'(ex_inst), 64'd0);
    chk("midrst_busy", 64'(dut.u_sb.busy), 64'd0);

    // Randomized traffic from a modelled in-order queue
    idle();
    for (int c = 0; c < 3000; c++) begin
      int adds;
      adds = $urandom_range(0, 2);
      for (int a = 0; a < adds; a++) if (q.size() < 6) q.push_back(rnd_elem());
      iq_size    = (q.size() >= 2) ? 2'd2 : 2'(q.size());
      iq_data[0] = (q.size() > 0) ? q[0] : rnd_elem();
      iq_data[1] = (q.size() > 1) ? q[1] : rnd_elem();
      ex_ready   = {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)};
      wb_valid   = {($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0)};
      wb_dest[0] = reg_addr_t'($urandom_range(0, 7));
      wb_dest[1] = reg_addr_t'($urandom_range(0, 7));
      flush      = ($urandom_range(0, 63) == 0);
      rst        = ($urandom_range(0, 255) == 0);
      cycle();
      if (rst || flush) begin
        q.delete();
      end else begin
        for (int p = 0; p < e_n; p++) void'(q.pop_front());
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
